// File: rtl/tinker_pkg.sv
// rtl/tinker_pkg.sv - shared opcodes, FSM state type and immediate helper for tinker_seq_exec
package tinker_pkg;

  localparam int MAX_XLEN = 128;

  localparam logic [4:0] OP_AND    = 5'h00;
  localparam logic [4:0] OP_OR     = 5'h01;
  localparam logic [4:0] OP_XOR    = 5'h02;
  localparam logic [4:0] OP_NOT    = 5'h03;
  localparam logic [4:0] OP_SHFTR  = 5'h04;
  localparam logic [4:0] OP_SHFTRI = 5'h05;
  localparam logic [4:0] OP_SHFTL  = 5'h06;
  localparam logic [4:0] OP_SHFTLI = 5'h07;
  localparam logic [4:0] OP_MOV_RR = 5'h11;
  localparam logic [4:0] OP_MOV_RL = 5'h12;
  localparam logic [4:0] OP_ADDF   = 5'h14;
  localparam logic [4:0] OP_ADD    = 5'h18;
  localparam logic [4:0] OP_ADDI   = 5'h19;
  localparam logic [4:0] OP_SUB    = 5'h1a;
  localparam logic [4:0] OP_SUBI   = 5'h1b;
  localparam logic [4:0] OP_MUL    = 5'h1c;
  localparam logic [4:0] OP_DIV    = 5'h1d;

  typedef enum logic {IDLE, DIV} exec_state_e;

  // Bits at and above xlen are cleared so callers may truncate without caring about the upper part.
  function automatic logic [MAX_XLEN-1:0] sext12(input logic [11:0] l, input int xlen);
    logic [MAX_XLEN-1:0] full;
    logic [MAX_XLEN-1:0] mask;
    full = {{(MAX_XLEN-12){l[11]}}, l};
    mask = ~({MAX_XLEN{1'b1}} << xlen);
    return full & mask;
  endfunction

endpackage

// File: rtl/tinker_divider.sv
// rtl/tinker_divider.sv - iterative unsigned restoring divider, DIV_RADIX quotient bits per cycle
module tinker_divider #(
  parameter int XLEN      = 64,
  parameter int DIV_RADIX = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient
);

  localparam int STEPS = XLEN / DIV_RADIX;
  localparam int CW    = $clog2(STEPS);

  logic [XLEN-1:0] q, r, d;
  logic [XLEN-1:0] q_next, r_next;
  logic [XLEN:0]   trial;
  logic [CW-1:0]   count;

  // The quotient register doubles as the dividend shift register; a zero divisor yields all ones.
  always_comb begin
    q_next = q;
    r_next = r;
    trial  = '0;
    for (int i = 0; i < DIV_RADIX; i++) begin
      trial  = {r_next, q_next[XLEN-1]};
      q_next = {q_next[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, d}) begin
        trial     = trial - {1'b0, d};
        q_next[0] = 1'b1;
      end
      r_next = trial[XLEN-1:0];
    end
  end

  assign done     = busy && (count == '0);
  assign quotient = q_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= 1'b0;
      count <= '0;
      q     <= '0;
      r     <= '0;
      d     <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      count <= CW'(STEPS - 1);
      q     <= dividend;
      r     <= '0;
      d     <= divisor;
    end else if (busy) begin
      q     <= q_next;
      r     <= r_next;
      count <= count - 1'b1;
      if (count == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/tinker_seq_exec.sv
// rtl/tinker_seq_exec.sv - clocked Tinker integer/MOV executor with register file and multi-cycle divide
module tinker_seq_exec
  import tinker_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int NREGS     = 32,
  parameter int DIV_RADIX = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instruction,
  output logic            retire_valid,
  output logic [4:0]      retire_rd,
  output logic [XLEN-1:0] retire_data,
  output logic            retire_illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int SHW = $clog2(XLEN);

  exec_state_e state, state_next;
  logic [XLEN-1:0] regs [NREGS];

  logic [4:0]      op, rd, rs, rt;
  logic [11:0]     l;
  logic [XLEN-1:0] a, b, dv, imm, alu;
  logic            legal, is_div, accept;
  logic            div_busy, div_done;
  logic [XLEN-1:0] div_q;
  logic [4:0]      div_rd;

  assign op  = instruction[31:27];
  assign rd  = instruction[26:22];
  assign rs  = instruction[21:17];
  assign rt  = instruction[16:12];
  assign l   = instruction[11:0];

  assign a   = regs[rs];
  assign b   = regs[rt];
  assign dv  = regs[rd];
  assign imm = XLEN'(sext12(l, XLEN));

  assign instr_ready = (state == IDLE) && !reset;
  assign accept      = instr_valid && instr_ready;
  assign dbg_data    = regs[dbg_addr];

  // Operands are read combinationally, so rd==rs/rt naturally sees the pre-write value.
  always_comb begin
    alu    = '0;
    legal  = 1'b1;
    is_div = 1'b0;
    case (op)
      OP_AND:    alu = a & b;
      OP_OR:     alu = a | b;
      OP_XOR:    alu = a ^ b;
      OP_NOT:    alu = ~a;
      OP_SHFTR:  alu = a >> b[SHW-1:0];
      OP_SHFTRI: alu = dv >> imm[SHW-1:0];
      OP_SHFTL:  alu = a << b[SHW-1:0];
      OP_SHFTLI: alu = dv << imm[SHW-1:0];
      OP_MOV_RR: alu = a;
      OP_MOV_RL: alu = imm;
      OP_ADD:    alu = a + b;
      OP_ADDI:   alu = dv + imm;
      OP_SUB:    alu = a - b;
      OP_SUBI:   alu = dv - imm;
      OP_MUL:    alu = a * b;
      OP_DIV:    is_div = 1'b1;
      default:   legal = 1'b0;
    endcase
  end

  tinker_divider #(.XLEN(XLEN), .DIV_RADIX(DIV_RADIX)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (accept && is_div),
    .dividend (a),
    .divisor  (b),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && is_div) state_next = DIV;
      DIV:  if (div_done || !div_busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      retire_valid   <= 1'b0;
      retire_rd      <= '0;
      retire_data    <= '0;
      retire_illegal <= 1'b0;
      div_rd         <= '0;
    end else begin
      retire_valid <= 1'b0;
      if (accept && is_div) begin
        div_rd <= rd;
      end else if (accept) begin
        if (legal) regs[rd] <= alu;
        retire_valid   <= 1'b1;
        retire_rd      <= rd;
        retire_data    <= legal ? alu : '0;
        retire_illegal <= !legal;
      end
      if (div_done) begin
        regs[div_rd]   <= div_q;
        retire_valid   <= 1'b1;
        retire_rd      <= div_rd;
        retire_data    <= div_q;
        retire_illegal <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tinker_seq_exec.sv
// tb/tb_tinker_seq_exec.sv - directed self-checking bench for tinker_seq_exec
module tb_tinker_seq_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic        retire_valid;
  logic [4:0]  retire_rd;
  logic [63:0] retire_data;
  logic        retire_illegal;
  logic [4:0]  dbg_addr;
  logic [63:0] dbg_data;

  int checks = 0;
  int errors = 0;
  logic [63:0] model [32];

  tinker_seq_exec #(.XLEN(64), .NREGS(32), .DIV_RADIX(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .retire_valid   (retire_valid),
    .retire_rd      (retire_rd),
    .retire_data    (retire_data),
    .retire_illegal (retire_illegal),
    .dbg_addr       (dbg_addr),
    .dbg_data       (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [11:0] l);
    return {op, rd, rs, rt, l};
  endfunction

  task automatic read_reg(input logic [4:0] r, output logic [63:0] v);
    dbg_addr = r;
    #1;
    v = dbg_data;
  endtask

  // Presents one instruction; returns at the negedge following the accepting edge.
  task automatic send(input logic [31:0] ins);
    instr_valid = 1'b1;
    instruction = ins;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic single(input string tag, input logic [31:0] ins, input logic [63:0] exp);
    logic [63:0] v;
    send(ins);
    check({tag, "_retire_valid"}, 64'(retire_valid), 64'd1);
    check({tag, "_retire_data"}, retire_data, exp);
    read_reg(ins[26:22], v);
    check({tag, "_reg"}, v, exp);
    model[ins[26:22]] = exp;
  endtask

  task automatic run_div(input string tag, input logic [63:0] exp);
    int cyc = 1;
    int low = 0;
    logic [63:0] v;
    send(enc(5'h1d, 5'd4, 5'd5, 5'd6, 12'd0));
    while (!retire_valid && cyc < 200) begin
      if (!instr_ready) low++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd65);
    check({tag, "_ready_low"}, 64'(low), 64'd64);
    check({tag, "_ready_after"}, 64'(instr_ready), 64'd1);
    check({tag, "_retire_rd"}, 64'(retire_rd), 64'd4);
    check({tag, "_retire_data"}, retire_data, exp);
    read_reg(5'd4, v);
    check({tag, "_reg"}, v, exp);
    model[4] = exp;
  endtask

  initial begin
    logic [63:0] v;
    int pulses;
    for (int i = 0; i < 32; i++) model[i] = '0;
    reset       = 1'b1;
    instr_valid = 1'b1;
    instruction = enc(5'h12, 5'd5, 5'd0, 5'd0, 12'd5);
    dbg_addr    = 5'd5;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ready", 64'(instr_ready), 64'd0);
      check("rst_retire", 64'(retire_valid), 64'd0);
      read_reg(5'd5, v);
      check("rst_r5", v, 64'd0);
    end
    reset       = 1'b0;
    instr_valid = 1'b0;
    #1;
    check("post_rst_ready", 64'(instr_ready), 64'd1);
    check("post_rst_data", retire_data, 64'd0);
    check("post_rst_rd", 64'(retire_rd), 64'd0);
    check("post_rst_illegal", 64'(retire_illegal), 64'd0);

    // Back-to-back: MOV r1,-1 then ADDI r1,2 must see the freshly written -1.
    single("mov_r1", enc(5'h12, 5'd1, 5'd0, 5'd0, 12'hFFF), 64'hFFFF_FFFF_FFFF_FFFF);
    single("addi_r1", enc(5'h19, 5'd1, 5'd0, 5'd0, 12'd2), 64'd1);
    @(negedge clk);
    check("single_pulse", 64'(retire_valid), 64'd0);

    single("mov_r2", enc(5'h12, 5'd2, 5'd0, 5'd0, 12'd67), 64'd67);
    single("shftl_mask", enc(5'h06, 5'd3, 5'd1, 5'd2, 12'd0), 64'd8);
    single("mov_r5", enc(5'h12, 5'd5, 5'd0, 5'd0, 12'd100), 64'd100);
    single("mov_r6", enc(5'h12, 5'd6, 5'd0, 5'd0, 12'd7), 64'd7);
    single("mul_r8", enc(5'h1c, 5'd8, 5'd5, 5'd6, 12'd0), 64'd700);
    single("sub_r9", enc(5'h1a, 5'd9, 5'd6, 5'd5, 12'd0), 64'hFFFF_FFFF_FFFF_FFA3);
    single("xor_self", enc(5'h02, 5'd8, 5'd8, 5'd5, 12'd0), 64'd700 ^ 64'd100);
    single("shftri", enc(5'h05, 5'd3, 5'd0, 5'd0, 12'd2), 64'd2);

    run_div("div", 64'd14);
    single("mov_r6_zero", enc(5'h12, 5'd6, 5'd0, 5'd0, 12'd0), 64'd0);
    run_div("div0", 64'hFFFF_FFFF_FFFF_FFFF);

    send(enc(5'h14, 5'd7, 5'd1, 5'd2, 12'd0));
    check("illegal_flag", 64'(retire_illegal), 64'd1);
    check("illegal_valid", 64'(retire_valid), 64'd1);
    check("illegal_data", retire_data, 64'd0);
    for (int i = 0; i < 32; i++) begin
      read_reg(5'(i), v);
      check($sformatf("illegal_r%0d", i), v, model[i]);
    end

    // Reset in the 10th divide cycle must drop the divide silently.
    single("mov_r6_again", enc(5'h12, 5'd6, 5'd0, 5'd0, 12'd7), 64'd7);
    send(enc(5'h1d, 5'd4, 5'd5, 5'd6, 12'd0));
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (retire_valid) pulses++;
    end
    check("abort_no_retire", 64'(pulses), 64'd0);
    check("abort_ready", 64'(instr_ready), 64'd1);
    read_reg(5'd4, v);
    check("abort_r4", v, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
